id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Pipelined instruction-decode stage for the 5-stage ARM-subset CPU; successor to the single-cycle ID datapath.
//  Decodes register/immediate fields from the 32-bit instruction and reads a parametrised bypassing register file.
//  Detects load-use hazards and registers all operands into an ID/EX pipeline register with valid/stall/flush.
//  Sits between the IF/ID register and the EX stage; write-back port is driven by the WB stage.
// PARAMETERS
//  DATA_W   64   datapath/register width (>=32)
//  NREGS    32   register count, power of 2; index NREGS-1 is the zero register (ZR)
//  CTRL_W   8    width of opaque control bundle passed to EX unchanged
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  reset         in   1       synchronous, active-low (0 = reset)
//  id_valid      in   1       IF/ID holds a valid instruction
//  id_instr      in   32      instruction word
//  id_pc         in   DATA_W  PC of instruction
//  reg2loc       in   1       1: Ab=Rm instr[20:16]; 0: Ab=Rt/Rd instr[4:0]
//  uncond_br     in   1       1: branch offset=imm26 instr[25:0]; 0: imm19 instr[23:5]
//  dt_sel        in   1       1: ex_imm=sext(imm9 instr[20:12]); 0: sext(imm12 instr[21:10])
//  mem_read      in   1       instruction is a load
//  reg_write     in   1       instruction writes Rd
//  ctrl_in       in   CTRL_W  remaining EX/MEM/WB control, passthrough
//  ex_stall      in   1       EX cannot accept; hold ID/EX
//  ex_flush      in   1       taken branch resolved; kill ID/EX contents
//  wb_we         in   1       write-back enable
//  wb_addr       in   log2(NREGS)  write-back register
//  wb_data       in   DATA_W  write-back data
//  wb_link_sel   in   1       1: write wb_link instead of wb_data (BL)
//  wb_link       in   DATA_W  link value (PC+4)
//  hazard_stall  out  1       comb: hold PC and IF/ID this cycle
//  ex_valid      out  1       ID/EX holds a valid instruction
//  ex_pc, ex_da, ex_db, ex_imm, ex_br_target  out DATA_W  registered operands
//  ex_rn, ex_rb, ex_rd  out  log2(NREGS)  registered source/dest indices (for forwarding)
//  ex_mem_read, ex_reg_write  out 1  registered control
//  ex_ctrl       out  CTRL_W  registered ctrl_in
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all ex_* outputs 0, ex_valid 0, all registers 0. Held for its full duration.
//  - Regfile: Da=R[Rn], Db=R[Ab]; ZR reads 0, writes to ZR ignored.
//  - Write data: Dw = wb_link_sel ? wb_link : wb_data; written at posedge when wb_we.
//  - Write-through bypass: if wb_we, wb_addr!=ZR and wb_addr matches a read address, that read returns Dw the same cycle.
//  - Branch target: ex_br_target = id_pc + (sext(offset)<<2), modulo 2^DATA_W.
//  - Load-use hazard (comb): load_use = id_valid & ex_valid & ex_mem_read & ex_rd!=ZR & (ex_rd==Rn | ex_rd==Ab).
//    Ab check applies only when reg2loc=1 or the instruction is a store (ctrl_in-independent: check both always; false stall acceptable but not required).
//  - hazard_stall = load_use | ex_stall.
//  - ID/EX update priority at posedge: reset > ex_flush > ex_stall > load_use > load.
//    ex_flush: ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0; data fields don't-care.
//    ex_stall: every ID/EX field holds.
//    load_use: insert bubble (ex_valid, ex_reg_write, ex_mem_read <=0); IF/ID held upstream by hazard_stall, so the same instruction re-decodes next cycle.
//    load: capture decode; ex_valid<=id_valid; ex_reg_write/ex_mem_read gated by id_valid.
//  - Latency: one cycle ID->EX; a load-use pair costs exactly one bubble.
//  - ex_flush and ex_stall together: flush wins.
//  - Regfile write occurs regardless of stall/flush.
// STRUCTURE
//  - Package cpu_pkg: instruction field bit positions, ZR_IDX function of NREGS, id_ex_t struct of the pipeline register.
//  - Sub-module regfile_bypass #(DATA_W,NREGS): 2R/1W, ZR, write-through bypass, sync active-low reset.
//  - Top: field decode, sign extend, target adder, hazard logic, id_ex_t register.
// TESTING
//  1. Reset low 2 cycles with inputs toggling -> all ex_* = 0, hazard_stall=ex_stall only; read any reg -> 0.
//  2. wb_we, wb_addr=8, wb_data=69 while id decodes Rn=8 same cycle -> ex_da=69 next cycle (bypass); ZR write of 5 -> reads 0.
//  3. wb_link_sel=1, wb_link=0x104, wb_addr=30 -> later read of X30 = 0x104.
//  4. Load to X3 in EX, ID instr Rn=3 -> hazard_stall=1 one cycle, bubble (ex_valid=0), then instr captured.
//  5. ex_flush with ex_stall both 1 -> ex_valid=0 next cycle; ex_stall alone 3 cycles -> ex_* unchanged.
//  6. id_pc=0x1000, uncond_br, imm26=-1 -> ex_br_target=0xFFC; imm19=0x40 -> 0x1100; DATA_W=32 wrap check.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU: instruction field positions,
// zero-register index and the control part of the ID/EX pipeline register.
package cpu_pkg;

    localparam int REG_FW    = 5;
    localparam int RD_LSB    = 0;
    localparam int RN_LSB    = 5;
    localparam int RM_LSB    = 16;

    localparam int IMM26_LSB = 0;
    localparam int IMM26_W   = 26;
    localparam int IMM19_LSB = 5;
    localparam int IMM19_W   = 19;
    localparam int IMM9_LSB  = 12;
    localparam int IMM9_W    = 9;
    localparam int IMM12_LSB = 10;
    localparam int IMM12_W   = 12;

    // The highest register index is hard-wired to zero.
    function automatic int zr_idx(input int nregs);
        return nregs - 1;
    endfunction

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic reg_write;
    } id_ex_t;

endpackage

// File: rtl/regfile_bypass.sv
// Two-read / one-write register file with a hard-wired zero register and
// write-through bypass so a same-cycle write is visible on the read ports.
module regfile_bypass
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] ra,
    input  logic [$clog2(NREGS)-1:0] rb,
    output logic [DATA_W-1:0]        da,
    output logic [DATA_W-1:0]        db,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZR = AW'(zr_idx(NREGS));

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_live;

    assign wr_live = we && (waddr != ZR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    assign da = (ra == ZR) ? '0 : (wr_live && waddr == ra) ? wdata : regs[ra];
    assign db = (rb == ZR) ? '0 : (wr_live && waddr == rb) ? wdata : regs[rb];

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined instruction-decode stage: field decode, register read with bypass,
// branch-target adder, load-use hazard detection and the ID/EX register.
module id_stage_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32,
    parameter int CTRL_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [31:0]              id_instr,
    input  logic [DATA_W-1:0]        id_pc,
    input  logic                     reg2loc,
    input  logic                     uncond_br,
    input  logic                     dt_sel,
    input  logic                     mem_read,
    input  logic                     reg_write,
    input  logic [CTRL_W-1:0]        ctrl_in,
    input  logic                     ex_stall,
    input  logic                     ex_flush,
    input  logic                     wb_we,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     wb_link_sel,
    input  logic [DATA_W-1:0]        wb_link,
    output logic                     hazard_stall,
    output logic                     ex_valid,
    output logic [DATA_W-1:0]        ex_pc,
    output logic [DATA_W-1:0]        ex_da,
    output logic [DATA_W-1:0]        ex_db,
    output logic [DATA_W-1:0]        ex_imm,
    output logic [DATA_W-1:0]        ex_br_target,
    output logic [$clog2(NREGS)-1:0] ex_rn,
    output logic [$clog2(NREGS)-1:0] ex_rb,
    output logic [$clog2(NREGS)-1:0] ex_rd,
    output logic                     ex_mem_read,
    output logic                     ex_reg_write,
    output logic [CTRL_W-1:0]        ex_ctrl
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZR = AW'(zr_idx(NREGS));

    typedef struct packed {
        id_ex_t            flags;
        logic [DATA_W-1:0] pc, da, db, imm, br_target;
        logic [AW-1:0]     rn, rb, rd;
        logic [CTRL_W-1:0] ctrl;
    } stage_t;

    stage_t            q, d;
    logic [AW-1:0]     rn, rm, rd, ab;
    logic [DATA_W-1:0] rf_da, rf_db, dw, imm, offset;
    logic              load_use;
    logic              unused_instr_bits;

    assign rn = AW'(id_instr[RN_LSB +: REG_FW]);
    assign rm = AW'(id_instr[RM_LSB +: REG_FW]);
    assign rd = AW'(id_instr[RD_LSB +: REG_FW]);
    assign ab = reg2loc ? rm : rd;
    assign unused_instr_bits = ^id_instr[31:26];

    assign imm = dt_sel ? DATA_W'($signed(id_instr[IMM9_LSB +: IMM9_W]))
                        : DATA_W'($signed(id_instr[IMM12_LSB +: IMM12_W]));
    assign offset = uncond_br ? DATA_W'($signed(id_instr[IMM26_LSB +: IMM26_W]))
                              : DATA_W'($signed(id_instr[IMM19_LSB +: IMM19_W]));

    assign dw = wb_link_sel ? wb_link : wb_data;

    regfile_bypass #(
        .DATA_W(DATA_W),
        .NREGS (NREGS)
    ) u_regfile (
        .clk  (clk),
        .reset(reset),
        .ra   (rn),
        .rb   (ab),
        .da   (rf_da),
        .db   (rf_db),
        .we   (wb_we),
        .waddr(wb_addr),
        .wdata(dw)
    );

    // Both source indices are always checked; an occasional false stall on a
    // field that is not really a source is harmless.
    assign load_use = id_valid & q.flags.valid & q.flags.mem_read & (q.rd != ZR)
                    & ((q.rd == rn) | (q.rd == ab));
    assign hazard_stall = load_use | ex_stall;

    always_comb begin
        d                 = '0;
        d.flags.valid     = id_valid;
        d.flags.mem_read  = id_valid & mem_read;
        d.flags.reg_write = id_valid & reg_write;
        d.pc              = id_pc;
        d.da              = rf_da;
        d.db              = rf_db;
        d.imm             = imm;
        d.br_target       = id_pc + (offset << 2);
        d.rn              = rn;
        d.rb              = ab;
        d.rd              = rd;
        d.ctrl            = ctrl_in;
    end

    // Flush beats stall; a load-use bubble only clears the control flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (ex_flush) begin
            q.flags <= '0;
        end else if (!ex_stall) begin
            if (load_use) begin
                q.flags <= '0;
            end else begin
                q <= d;
            end
        end
    end

    assign ex_valid     = q.flags.valid;
    assign ex_mem_read  = q.flags.mem_read;
    assign ex_reg_write = q.flags.reg_write;
    assign ex_pc        = q.pc;
    assign ex_da        = q.da;
    assign ex_db        = q.db;
    assign ex_imm       = q.imm;
    assign ex_br_target = q.br_target;
    assign ex_rn        = q.rn;
    assign ex_rb        = q.rb;
    assign ex_rd        = q.rd;
    assign ex_ctrl      = q.ctrl;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus a randomized run, all
// checked against a behavioural model of the decode stage kept in the bench.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [31:0] id_pc32;
  logic        reg2loc, uncond_br, dt_sel, mem_read, reg_write;
  logic [7:0]  ctrl_in;
  logic        ex_stall, ex_flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        wb_link_sel;
  logic [63:0] wb_link;

  logic        hazard_stall, ex_valid, ex_mem_read, ex_reg_write;
  logic [63:0] ex_pc, ex_da, ex_db, ex_imm, ex_br_target;
  logic [4:0]  ex_rn, ex_rb, ex_rd;
  logic [7:0]  ex_ctrl;

  logic        n_hazard_stall, n_valid, n_mem_read, n_reg_write;
  logic [31:0] n_pc, n_da, n_db, n_imm, n_br_target;
  logic [4:0]  n_rn, n_rb, n_rd;
  logic [7:0]  n_ctrl;

  int checks = 0;
  int errors = 0;

  // model state: architectural registers and the expected ID/EX contents
  logic [63:0] ref_rf [32];
  logic        m_valid, m_mr, m_rw;
  logic [63:0] m_pc, m_da, m_db, m_imm, m_br;
  logic [4:0]  m_rn, m_rb, m_rd;
  logic [7:0]  m_ctrl;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(64), .NREGS(32), .CTRL_W(8)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .reg2loc(reg2loc), .uncond_br(uncond_br), .dt_sel(dt_sel),
    .mem_read(mem_read), .reg_write(reg_write), .ctrl_in(ctrl_in),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_link_sel(wb_link_sel), .wb_link(wb_link),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_da(ex_da), .ex_db(ex_db), .ex_imm(ex_imm), .ex_br_target(ex_br_target),
    .ex_rn(ex_rn), .ex_rb(ex_rb), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_ctrl(ex_ctrl)
  );

  id_stage_pipe #(.DATA_W(32), .NREGS(32), .CTRL_W(8)) dut32 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc32), .reg2loc(reg2loc), .uncond_br(uncond_br), .dt_sel(dt_sel),
    .mem_read(mem_read), .reg_write(reg_write), .ctrl_in(ctrl_in),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data[31:0]), .wb_link_sel(wb_link_sel), .wb_link(wb_link[31:0]),
    .hazard_stall(n_hazard_stall), .ex_valid(n_valid), .ex_pc(n_pc),
    .ex_da(n_da), .ex_db(n_db), .ex_imm(n_imm), .ex_br_target(n_br_target),
    .ex_rn(n_rn), .ex_rb(n_rb), .ex_rd(n_rd), .ex_mem_read(n_mem_read),
    .ex_reg_write(n_reg_write), .ex_ctrl(n_ctrl)
  );

  // ---------------- reference model ----------------
  function automatic longint sext(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic logic [63:0] model_read(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (wb_we && wb_addr == a) return wb_link_sel ? wb_link : wb_data;
    return ref_rf[a];
  endfunction

  function automatic bit model_load_use();
    logic [4:0] rn, ab;
    rn = id_instr[9:5];
    ab = reg2loc ? id_instr[20:16] : id_instr[4:0];
    return id_valid && m_valid && m_mr && m_rd != 5'd31 && (m_rd == rn || m_rd == ab);
  endfunction

  // Advance one clock: compute the model's next state from the current inputs,
  // take the edge, then commit.
  task automatic tick();
    logic [4:0]  rn, ab;
    longint      off, immv;
    bit          lu, do_wr;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [63:0] n_da_v, n_db_v, n_br_v;
    rn     = id_instr[9:5];
    ab     = reg2loc ? id_instr[20:16] : id_instr[4:0];
    lu     = model_load_use();
    n_da_v = model_read(rn);
    n_db_v = model_read(ab);
    immv   = dt_sel ? sext(longint'(id_instr[20:12]), 9) : sext(longint'(id_instr[21:10]), 12);
    off    = uncond_br ? sext(longint'(id_instr[25:0]), 26) : sext(longint'(id_instr[23:5]), 19);
    n_br_v = id_pc + 64'(off * 4);
    do_wr  = reset && wb_we && wb_addr != 5'd31;
    wa     = wb_addr;
    wd     = wb_link_sel ? wb_link : wb_data;
    @(posedge clk);
    #1;
    if (!reset) begin
      foreach (ref_rf[i]) ref_rf[i] = 64'd0;
      {m_valid, m_mr, m_rw} = 3'b000;
      {m_pc, m_da, m_db, m_imm, m_br} = '0;
      {m_rn, m_rb, m_rd, m_ctrl} = '0;
    end else begin
      if (ex_flush || (!ex_stall && lu)) begin
        {m_valid, m_mr, m_rw} = 3'b000;
      end else if (!ex_stall) begin
        m_valid = id_valid;
        m_mr    = id_valid && mem_read;
        m_rw    = id_valid && reg_write;
        m_pc    = id_pc;
        m_da    = n_da_v;
        m_db    = n_db_v;
        m_imm   = 64'(immv);
        m_br    = n_br_v;
        m_rn    = rn;
        m_rb    = ab;
        m_rd    = id_instr[4:0];
        m_ctrl  = ctrl_in;
      end
      if (do_wr) ref_rf[wa] = wd;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_idle();
    reset = 1'b1; id_valid = 1'b0; id_instr = 32'd0; id_pc = 64'd0; id_pc32 = 32'd0;
    reg2loc = 1'b0; uncond_br = 1'b0; dt_sel = 1'b0; mem_read = 1'b0; reg_write = 1'b0;
    ctrl_in = 8'd0; ex_stall = 1'b0; ex_flush = 1'b0; wb_we = 1'b0; wb_addr = 5'd0;
    wb_data = 64'd0; wb_link_sel = 1'b0; wb_link = 64'd0;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic drive_random(input bit allow_ctl);
    id_valid    = ($urandom_range(0, 3) != 0);
    id_instr    = $urandom;
    id_instr[4:0]   = pick_reg();
    id_instr[9:5]   = pick_reg();
    id_instr[20:16] = pick_reg();
    id_pc       = {$urandom, $urandom};
    id_pc32     = $urandom;
    reg2loc     = 1'($urandom_range(0, 1));
    uncond_br   = 1'($urandom_range(0, 1));
    dt_sel      = 1'($urandom_range(0, 1));
    mem_read    = ($urandom_range(0, 2) == 0);
    reg_write   = 1'($urandom_range(0, 1));
    ctrl_in     = 8'($urandom);
    ex_stall    = allow_ctl && ($urandom_range(0, 9) == 0);
    ex_flush    = allow_ctl && ($urandom_range(0, 14) == 0);
    wb_we       = 1'($urandom_range(0, 1));
    wb_addr     = pick_reg();
    wb_data     = {$urandom, $urandom};
    wb_link_sel = ($urandom_range(0, 3) == 0);
    wb_link     = {$urandom, $urandom};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    drive_random(1'b1);
    reset = 1'b0;
    tick();
    for (int c = 0; c < 2; c++) begin
      drive_random(1'b1);
      reset = 1'b0;
      #1;
      checks++;
      if (hazard_stall !== ex_stall) begin
        errors++;
        $display("FAIL reset_hazard got %b exp %b", hazard_stall, ex_stall);
      end
      tick();
    end
    checks++;
    if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000", {ex_valid, ex_mem_read, ex_reg_write});
    end
    checks++;
    if ({ex_pc, ex_da, ex_db, ex_imm, ex_br_target, ex_rn, ex_rb, ex_rd, ex_ctrl} !== '0) begin
      errors++;
      $display("FAIL reset_data got pc=%h da=%h db=%h imm=%h br=%h exp all zero",
               ex_pc, ex_da, ex_db, ex_imm, ex_br_target);
    end
    for (int r = 0; r < 4; r++) begin
      set_idle();
      id_valid = 1'b1;
      reg2loc  = 1'b1;
      id_instr[9:5]   = 5'($urandom_range(0, 31));
      id_instr[20:16] = 5'($urandom_range(0, 31));
      tick();
      checks++;
      if (ex_da !== 64'd0 || ex_db !== 64'd0) begin
        errors++;
        $display("FAIL reset_regread got da=%h db=%h exp 0", ex_da, ex_db);
      end
    end
  endtask

  task automatic test_bypass();
    set_idle();
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 64'd69;
    id_valid = 1'b1; id_instr[9:5] = 5'd8;
    tick();
    checks++;
    if (ex_da !== 64'd69) begin
      errors++;
      $display("FAIL bypass_x8 got %h exp %h", ex_da, 64'd69);
    end
    set_idle();
    wb_we = 1'b1; wb_addr = 5'd31; wb_data = 64'd5;
    id_valid = 1'b1; id_instr[9:5] = 5'd31;
    tick();
    checks++;
    if (ex_da !== 64'd0) begin
      errors++;
      $display("FAIL bypass_zr got %h exp 0", ex_da);
    end
    set_idle();
    id_valid = 1'b1; id_instr[9:5] = 5'd8;
    tick();
    checks++;
    if (ex_da !== 64'd69) begin
      errors++;
      $display("FAIL stored_x8 got %h exp %h", ex_da, 64'd69);
    end
  endtask

  task automatic test_link();
    set_idle();
    wb_we = 1'b1; wb_addr = 5'd30; wb_link_sel = 1'b1;
    wb_link = 64'h104; wb_data = {$urandom, $urandom};
    tick();
    set_idle();
    id_valid = 1'b1; reg2loc = 1'b1;
    id_instr[9:5] = 5'd30; id_instr[20:16] = 5'd30;
    tick();
    checks++;
    if (ex_da !== 64'h104 || ex_db !== 64'h104) begin
      errors++;
      $display("FAIL link_x30 got da=%h db=%h exp %h", ex_da, ex_db, 64'h104);
    end
  endtask

  task automatic test_load_use();
    set_idle();
    id_valid = 1'b1; mem_read = 1'b1; reg_write = 1'b1; id_instr = 32'd3;
    tick();
    set_idle();
    id_valid = 1'b1; reg_write = 1'b1;
    id_instr = (32'd3 << 5) | 32'd7;
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_stall got %b exp 1", hazard_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_bubble got valid=%b stall=%b exp 0 0", ex_valid, hazard_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rn !== 5'd3 || ex_rd !== 5'd7 || ex_mem_read !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_capture got valid=%b rn=%0d rd=%0d mr=%b exp 1 3 7 0",
               ex_valid, ex_rn, ex_rd, ex_mem_read);
    end
  endtask

  task automatic test_stall_flush();
    logic [63:0] s_pc, s_da, s_imm, s_br;
    logic [7:0]  s_ctrl;
    logic [4:0]  s_rd;
    drive_random(1'b0);
    id_valid = 1'b1;
    tick();
    ex_stall = 1'b1; ex_flush = 1'b1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_stall got %b exp 000", {ex_valid, ex_reg_write, ex_mem_read});
    end
    drive_random(1'b0);
    id_valid = 1'b1; reg_write = 1'b1; mem_read = 1'b0;
    tick();
    s_pc = m_pc; s_da = m_da; s_imm = m_imm; s_br = m_br; s_ctrl = m_ctrl; s_rd = m_rd;
    for (int c = 0; c < 3; c++) begin
      drive_random(1'b0);
      ex_stall = 1'b1;
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_pc !== s_pc || ex_da !== s_da ||
          ex_imm !== s_imm || ex_br_target !== s_br || ex_ctrl !== s_ctrl || ex_rd !== s_rd) begin
        errors++;
        $display("FAIL stall_hold got pc=%h da=%h imm=%h br=%h exp pc=%h da=%h imm=%h br=%h",
                 ex_pc, ex_da, ex_imm, ex_br_target, s_pc, s_da, s_imm, s_br);
      end
    end
  endtask

  task automatic test_branch();
    set_idle();
    id_valid = 1'b1; id_pc = 64'h1000; uncond_br = 1'b1; id_instr = 32'h03FF_FFFF;
    tick();
    checks++;
    if (ex_br_target !== 64'hFFC) begin
      errors++;
      $display("FAIL br_imm26_neg got %h exp %h", ex_br_target, 64'hFFC);
    end
    uncond_br = 1'b0; id_instr = 32'h40 << 5;
    tick();
    checks++;
    if (ex_br_target !== 64'h1100) begin
      errors++;
      $display("FAIL br_imm19 got %h exp %h", ex_br_target, 64'h1100);
    end
    id_pc = 64'hFFFF_FFFF_FFFF_FFF0; id_pc32 = 32'hFFFF_FFF0; id_instr = 32'h10 << 5;
    tick();
    checks++;
    if (ex_br_target !== 64'h30 || n_br_target !== 32'h30) begin
      errors++;
      $display("FAIL br_wrap got %h / %h exp 30 / 30", ex_br_target, n_br_target);
    end
    dt_sel = 1'b1; id_instr = 32'h1FE << 12;
    tick();
    checks++;
    if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFFE || n_imm !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL imm9_sext got %h / %h exp -2", ex_imm, n_imm);
    end
    dt_sel = 1'b0; id_instr = 32'h800 << 10;
    tick();
    checks++;
    if (ex_imm !== 64'hFFFF_FFFF_FFFF_F800) begin
      errors++;
      $display("FAIL imm12_sext got %h exp %h", ex_imm, 64'hFFFF_FFFF_FFFF_F800);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive_random(1'b1);
      #1;
      checks++;
      if (hazard_stall !== (model_load_use() || ex_stall)) begin
        errors++;
        $display("FAIL rand_hazard cycle %0d got %b exp %b", c, hazard_stall,
                 model_load_use() || ex_stall);
      end
      tick();
      checks++;
      if ({ex_valid, ex_mem_read, ex_reg_write} !== {m_valid, m_mr, m_rw}) begin
        errors++;
        $display("FAIL rand_flags cycle %0d got %b exp %b", c,
                 {ex_valid, ex_mem_read, ex_reg_write}, {m_valid, m_mr, m_rw});
      end
      if (m_valid) begin
        checks++;
        if ({ex_pc, ex_da, ex_db, ex_imm, ex_br_target, ex_rn, ex_rb, ex_rd, ex_ctrl} !==
            {m_pc, m_da, m_db, m_imm, m_br, m_rn, m_rb, m_rd, m_ctrl}) begin
          errors++;
          $display("FAIL rand_data cycle %0d got pc=%h da=%h db=%h imm=%h br=%h rn=%0d rb=%0d rd=%0d ctrl=%h exp pc=%h da=%h db=%h imm=%h br=%h rn=%0d rb=%0d rd=%0d ctrl=%h",
                   c, ex_pc, ex_da, ex_db, ex_imm, ex_br_target, ex_rn, ex_rb, ex_rd, ex_ctrl,
                   m_pc, m_da, m_db, m_imm, m_br, m_rn, m_rb, m_rd, m_ctrl);
        end
      end
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_bypass();
    test_link();
    test_load_use();
    test_stall_flush();
    test_branch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
